// File: rtl/jpeg_hdmi_pkg.sv
// Shared types and geometry helpers for the HDMI capture front end.
package jpeg_hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    RESYNC  = 2'd3
  } state_t;

  localparam int BLOCK_SIZE = 8;

  function automatic int beats_per_line(input int x_res, input int n);
    return x_res / n;
  endfunction

  function automatic int blocks_per_stripe(input int x_res);
    return x_res / BLOCK_SIZE;
  endfunction

endpackage

// File: rtl/stripe_tracker.sv
// Tracks stripes held in the ping-pong buffer against blocks drained by the
// converter; flags overrun and signals frame completion.
module stripe_tracker
  import jpeg_hdmi_pkg::*;
#(
  parameter int BLOCKS = 270
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stripe_wr,
  input  logic        last_stripe,
  input  logic        blk_eob,
  output logic        overrun,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int EW = $clog2(BLOCKS + 1);
  localparam logic [EW-1:0] EOB_LAST = EW'(BLOCKS - 1);

  logic [EW-1:0] eob_cnt;
  logic [1:0]    outstanding;
  logic          last_pending;
  logic          dec;
  logic          inc;
  logic          done_ev;

  // Drain/fill events; an overrunning stripe is never counted as held.
  always_comb begin
    dec     = blk_eob && (eob_cnt == EOB_LAST);
    overrun = stripe_wr && (outstanding == 2'd1) && !dec;
    inc     = stripe_wr && !overrun;
    done_ev = dec && !inc && (outstanding == 2'd1) && last_pending;
  end

  // Occupancy, block counting and frame completion state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eob_cnt      <= '0;
      outstanding  <= 2'd0;
      last_pending <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      if (blk_eob) begin
        eob_cnt <= dec ? '0 : eob_cnt + 1'b1;
      end
      if (inc && !dec) begin
        outstanding <= outstanding + 2'd1;
      end else if (dec && !inc && (outstanding != 2'd0)) begin
        outstanding <= outstanding - 2'd1;
      end
      last_pending <= (last_pending && !done_ev) || (inc && last_stripe);
      frame_done   <= done_ev;
      if (done_ev) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// Frame/stripe sequencer: locks to HDMI syncs, checks geometry and gates
// beats into the line-buffer converter.
module hdmi_stream_ctrl
  import jpeg_hdmi_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   err_clr,
  input  logic                                   hdmi_v_sync,
  input  logic                                   hdmi_h_sync,
  input  logic                                   hdmi_data_valid,
  input  logic                                   blk_eob,
  output logic                                   cvt_v_sync,
  output logic                                   cvt_data_valid,
  output logic                                   frame_active,
  output logic                                   frame_done,
  output logic [15:0]                            frame_cnt,
  output logic [$clog2(Y_RES/BLOCK_SIZE)-1:0]    stripe_idx,
  output logic                                   err_line_len,
  output logic                                   err_frame_len,
  output logic                                   err_overrun
);

  localparam int BEATS   = beats_per_line(X_RES, N);
  localparam int BLOCKS  = blocks_per_stripe(X_RES);
  localparam int STRIPES = Y_RES / BLOCK_SIZE;
  localparam int PW      = $clog2(BEATS + 1);
  localparam int LW      = $clog2(Y_RES);
  localparam int SW      = $clog2(STRIPES);
  localparam int BW      = $clog2(BLOCK_SIZE);

  localparam logic [PW-1:0] PIX_FULL    = PW'(BEATS);
  localparam logic [PW-1:0] PIX_LAST    = PW'(BEATS - 1);
  localparam logic [LW-1:0] LINE_LAST   = LW'(Y_RES - 1);
  localparam logic [BW-1:0] ROW_LAST    = BW'(BLOCK_SIZE - 1);
  localparam logic [SW-1:0] STRIPE_LAST = SW'(STRIPES - 1);

  state_t        state;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          beat_ok;
  logic          line_end;
  logic          stripe_wr;
  logic          frame_end;
  logic          overrun;
  logic          line_err;
  logic          frame_err;

  assign frame_active = (state == ACTIVE);

  // Zero-latency beat gating and geometry events from the current counters.
  always_comb begin
    cvt_data_valid = hdmi_data_valid && (state == ACTIVE) && (pix_cnt < PIX_FULL);
    cvt_v_sync     = hdmi_v_sync && (((state == WAIT_VS) && en) || (state == ACTIVE) ||
                                     ((state == RESYNC) && en));
    beat_ok        = cvt_data_valid && !hdmi_v_sync && !hdmi_h_sync;
    line_end       = beat_ok && (pix_cnt == PIX_LAST);
    stripe_wr      = line_end && (line_cnt[BW-1:0] == ROW_LAST);
    frame_end      = line_end && (line_cnt == LINE_LAST);
    frame_err      = (state == ACTIVE) && hdmi_v_sync;
    line_err       = (state == ACTIVE) && !hdmi_v_sync &&
                     ((hdmi_h_sync && (pix_cnt != '0) && (pix_cnt != PIX_FULL)) ||
                      (!hdmi_h_sync && hdmi_data_valid && (pix_cnt == PIX_FULL)));
  end

  // Sequencer state, line geometry counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      stripe_idx    <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      err_line_len  <= line_err  || (err_line_len  && !err_clr);
      err_frame_len <= frame_err || (err_frame_len && !err_clr);
      err_overrun   <= overrun   || (err_overrun   && !err_clr);
      case (state)
        IDLE: begin
          if (en) begin
            state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (!en) begin
            state <= IDLE;
          end else if (hdmi_v_sync) begin
            state      <= ACTIVE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            stripe_idx <= '0;
          end
        end
        ACTIVE: begin
          if (hdmi_v_sync) begin
            // Early v_sync: accept the new frame from its first line.
            pix_cnt    <= '0;
            line_cnt   <= '0;
            stripe_idx <= '0;
          end else if (hdmi_h_sync) begin
            if (line_err) begin
              state <= RESYNC;
            end else begin
              pix_cnt <= '0;
              if (pix_cnt != '0) begin
                line_cnt <= line_cnt + 1'b1;
              end
            end
          end else if (beat_ok) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (stripe_wr) begin
              stripe_idx <= (stripe_idx == STRIPE_LAST) ? '0 : stripe_idx + 1'b1;
            end
            if (overrun) begin
              state <= RESYNC;
            end else if (frame_end) begin
              state <= WAIT_VS;
            end
          end
        end
        RESYNC: begin
          if (hdmi_v_sync) begin
            state      <= en ? ACTIVE : IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            stripe_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stripe_tracker #(
    .BLOCKS(BLOCKS)
  ) u_stripe_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .stripe_wr  (stripe_wr),
    .last_stripe(frame_end),
    .blk_eob    (blk_eob),
    .overrun    (overrun),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Scoreboard bench for hdmi_stream_ctrl on a 16x16 frame (8 beats/line,
// 2 stripes, 2 blocks per stripe).
module tb_hdmi_stream_ctrl;

  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int Y_RES = 16;
  localparam int SW    = $clog2(Y_RES / 8);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          err_clr = 1'b0;
  logic          hdmi_v_sync = 1'b0;
  logic          hdmi_h_sync = 1'b0;
  logic          hdmi_data_valid = 1'b0;
  logic          blk_eob = 1'b0;
  logic          cvt_v_sync;
  logic          cvt_data_valid;
  logic          frame_active;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic [SW-1:0] stripe_idx;
  logic          err_line_len;
  logic          err_frame_len;
  logic          err_overrun;

  hdmi_stream_ctrl #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .err_clr        (err_clr),
    .hdmi_v_sync    (hdmi_v_sync),
    .hdmi_h_sync    (hdmi_h_sync),
    .hdmi_data_valid(hdmi_data_valid),
    .blk_eob        (blk_eob),
    .cvt_v_sync     (cvt_v_sync),
    .cvt_data_valid (cvt_data_valid),
    .frame_active   (frame_active),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .stripe_idx     (stripe_idx),
    .err_line_len   (err_line_len),
    .err_frame_len  (err_frame_len),
    .err_overrun    (err_overrun)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_ACTIVE, S_FCNT, S_STRIPE, S_ELINE, S_EFRAME, S_EOVR,
    S_CVS, S_CDV, S_DONE, S_BEATS, S_QEMPTY
  } sig_e;

  typedef struct {
    sig_e sig;
    int   exp;
  } chk_t;

  chk_t chk_q[$];
  int   exp_beats[$];
  int   exp_done[$];
  int   checks = 0;
  int   errors = 0;
  int   beats_seen = 0;
  int   exp_total = 0;

  function automatic int actual(input sig_e s);
    case (s)
      S_ACTIVE: return int'(frame_active);
      S_FCNT:   return int'(frame_cnt);
      S_STRIPE: return int'(stripe_idx);
      S_ELINE:  return int'(err_line_len);
      S_EFRAME: return int'(err_frame_len);
      S_EOVR:   return int'(err_overrun);
      S_CVS:    return int'(cvt_v_sync);
      S_CDV:    return int'(cvt_data_valid);
      S_DONE:   return int'(frame_done);
      S_BEATS:  return beats_seen;
      S_QEMPTY: return exp_beats.size() + exp_done.size();
      default:  return -1;
    endcase
  endfunction

  // Monitor: pops expected beats/frame completions and queued status checks.
  always @(negedge clk) begin : monitor
    chk_t c;
    int   a;
    int   e;
    if (cvt_data_valid) begin
      beats_seen++;
      checks++;
      if (exp_beats.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: actual cvt_data_valid=1, required 0 at %0t", $time);
      end else begin
        e = exp_beats.pop_front();
        if (int'(stripe_idx) != e) begin
          errors++;
          $display("FAIL beat_stripe: actual %0d, required %0d at %0t", stripe_idx, e, $time);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: actual frame_done=1, required 0 at %0t", $time);
      end else begin
        e = exp_done.pop_front();
        if (int'(frame_cnt) != e) begin
          errors++;
          $display("FAIL done_frame_cnt: actual %0d, required %0d at %0t", frame_cnt, e, $time);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      a = actual(c.sig);
      checks++;
      if (a != c.exp) begin
        errors++;
        $display("FAIL %s: actual %0d, required %0d at %0t", c.sig.name(), a, c.exp, $time);
      end
    end
  end

  task automatic expect_val(input sig_e s, input int v);
    chk_t c;
    c.sig = s;
    c.exp = v;
    chk_q.push_back(c);
  endtask

  task automatic tick(input logic vs, input logic hs, input logic dv, input logic eob);
    hdmi_v_sync     = vs;
    hdmi_h_sync     = hs;
    hdmi_data_valid = dv;
    blk_eob         = eob;
    @(posedge clk);
    #1;
    hdmi_v_sync     = 1'b0;
    hdmi_h_sync     = 1'b0;
    hdmi_data_valid = 1'b0;
    blk_eob         = 1'b0;
  endtask

  task automatic vsync(input int exp_cvs);
    expect_val(S_CVS, exp_cvs);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int nb, input int n_acc, input int stripe);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i < n_acc) begin
        exp_beats.push_back(stripe);
        exp_total++;
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic eobs(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_lines(input int first, input int last, input int done_cnt);
    for (int l = first; l <= last; l++) begin
      line(8, 8, l / 8);
      if ((l % 8) == 7) begin
        if ((l == 15) && (done_cnt > 0)) exp_done.push_back(done_cnt);
        eobs(2);
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs();
    expect_val(S_ACTIVE, 0);
    expect_val(S_FCNT, 0);
    expect_val(S_STRIPE, 0);
    expect_val(S_ELINE, 0);
    expect_val(S_EFRAME, 0);
    expect_val(S_EOVR, 0);
    expect_val(S_CDV, 0);
    expect_val(S_CVS, 0);
    expect_val(S_DONE, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state and nominal frame
    do_reset();
    check_idle_outputs();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    expect_val(S_ACTIVE, 1);
    run_lines(0, 15, 1);
    expect_val(S_FCNT, 1);
    expect_val(S_STRIPE, 0);
    expect_val(S_ACTIVE, 0);
    expect_val(S_ELINE, 0);
    expect_val(S_EFRAME, 0);
    expect_val(S_EOVR, 0);
    expect_val(S_BEATS, 128);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Short line on line 3
    do_reset();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 2, 0);
    line(5, 5, 0);
    line(8, 0, 0);
    expect_val(S_ELINE, 1);
    expect_val(S_ACTIVE, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 15, 1);
    expect_val(S_FCNT, 1);
    expect_val(S_ELINE, 1);
    pulse_clr();
    expect_val(S_ELINE, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Long line of 10 beats
    do_reset();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 1, 0);
    line(10, 8, 0);
    expect_val(S_ELINE, 1);
    expect_val(S_ACTIVE, 1);
    run_lines(3, 15, 1);
    expect_val(S_FCNT, 1);
    expect_val(S_EFRAME, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Overrun: both stripes written without drain
    do_reset();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    for (int l = 0; l < 16; l++) line(8, 8, l / 8);
    expect_val(S_EOVR, 1);
    expect_val(S_ACTIVE, 0);
    expect_val(S_ELINE, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    expect_val(S_EOVR, 0);
    eobs(2);
    expect_val(S_FCNT, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Early v_sync after 12 lines
    do_reset();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 11, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    expect_val(S_EFRAME, 1);
    expect_val(S_ACTIVE, 1);
    expect_val(S_STRIPE, 0);
    run_lines(0, 15, 1);
    expect_val(S_FCNT, 1);
    expect_val(S_ELINE, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an active frame
    do_reset();
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 15, 1);
    vsync(1);
    run_lines(0, 9, 0);
    expect_val(S_ACTIVE, 1);
    expect_val(S_STRIPE, 1);
    expect_val(S_FCNT, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    hdmi_data_valid = 1'b1;
    rst_n = 1'b0;
    expect_val(S_CDV, 0);
    expect_val(S_ACTIVE, 0);
    expect_val(S_STRIPE, 0);
    expect_val(S_FCNT, 0);
    @(negedge clk);
    #1;
    hdmi_data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Enable dropped mid-frame: frame finishes, then IDLE ignores v_sync
    en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1);
    run_lines(0, 7, 0);
    en = 1'b0;
    run_lines(8, 15, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    vsync(0);
    line(8, 0, 0);
    expect_val(S_ACTIVE, 0);
    expect_val(S_FCNT, 1);
    expect_val(S_BEATS, exp_total);
    expect_val(S_QEMPTY, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
